cnt1_vec_arb: RTL and testbench
===============================

CNT1_VEC_ARB -- requirements
Module: cnt1_vec_arb

Interface
REQ-001 Parameter REQ_NO, default 4: number of requester streams sharing one cnt1 pipeline.
REQ-002 Parameter VECTOR_WIDTH, default 920: full fingerprint vector width in bits.
REQ-003 Parameter BUS_WIDTH, default 128: sub-vector (beat) width.
REQ-004 Parameter SUB_VECTOR_NO, default ceil(VECTOR_WIDTH/BUS_WIDTH) = 8: beats per vector.
REQ-005 Parameter VEC_ID_WIDTH, default 16: vector ID width.
REQ-006 Localparam SRC_WIDTH = max(1, clog2(REQ_NO)); localparam BEAT_CNTR_WIDTH = max(1, clog2(SUB_VECTOR_NO)).
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rstn  input  1  asynchronous, active-low reset.
REQ-009 up_Vector  input  REQ_NO*BUS_WIDTH  requester beats; requester k occupies slice [k*BUS_WIDTH +: BUS_WIDTH].
REQ-010 up_ID  input  REQ_NO*VEC_ID_WIDTH  requester vector IDs, sliced the same way.
REQ-011 up_Valid  input  REQ_NO  per-requester beat valid.
REQ-012 up_Last  input  REQ_NO  per-requester end-of-stream marker, asserted on the final beat of the final vector.
REQ-013 up_Ready  output  REQ_NO  per-requester beat accept.
REQ-014 dn_SubVector  output  BUS_WIDTH  registered beat to cnt1.
REQ-015 dn_ID  output  VEC_ID_WIDTH  registered ID to cnt1.
REQ-016 dn_Valid  output  1  registered beat valid.
REQ-017 dn_Last  output  1  registered end-of-stream marker.
REQ-018 dn_Src  output  SRC_WIDTH  index of the requester that owns the current dn beat.
REQ-019 dn_Ready  input  1  cnt1 up_Ready.
REQ-020 o_Busy  output  1  high while a grant is held (state BURST).
REQ-021 o_Err  output  1  sticky protocol-error flag.

Function
REQ-022 Upstream transfer on requester k: up_Valid[k] && up_Ready[k]; downstream transfer: dn_Valid && dn_Ready.
REQ-023 up_Ready[k] = (state == BURST) && (r_Grant == k) && (!dn_Valid || dn_Ready); all other up_Ready bits are 0.
REQ-024 Output stage: one register slot; it loads the granted requester's beat on an upstream transfer.
REQ-025 The output slot clears dn_Valid on a downstream transfer that coincides with no upstream transfer.
REQ-026 The output slot holds all dn outputs stable while dn_Valid && !dn_Ready.
REQ-027 FSM states: IDLE (no grant) and BURST (grant locked to r_Grant for one whole vector).
REQ-028 Arbitration is round-robin with search order r_Ptr+1, r_Ptr+2, ..., r_Ptr, modulo REQ_NO, over requesters with up_Valid high.
REQ-029 IDLE -> BURST when any up_Valid bit is high: r_Grant is loaded with the arbitration winner and r_BeatCntr with 0.
REQ-030 IDLE holds with no state change when all up_Valid bits are low.
REQ-031 In BURST, each upstream transfer increments r_BeatCntr.
REQ-032 Vector end is an upstream transfer with r_BeatCntr == SUB_VECTOR_NO-1.
REQ-033 At vector end: r_Ptr <= r_Grant, and the same cycle re-arbitrates over current up_Valid with r_Ptr updated, giving zero-bubble back-to-back grants.
REQ-034 At vector end: the FSM returns to IDLE if no up_Valid is high; otherwise r_BeatCntr <= 0 and r_Grant <= winner.
REQ-035 The grant is never revoked mid-vector; up_Valid low from the grantee inserts bubbles only.
REQ-036 up_Last accepted with r_BeatCntr != SUB_VECTOR_NO-1 sets o_Err and forwards the beat.
REQ-037 That early up_Last is treated as vector end: release, pointer update and re-arbitration per REQ-033/034.
REQ-038 o_Err clears only on reset.
REQ-039 Simultaneous vector end and downstream stall is impossible by construction: up_Ready is low while the slot is full and not draining.
REQ-040 dn_Src is registered with the beat and equals the owner of the beat presented on dn_SubVector.

Reset
REQ-041 On rstn low, asynchronously: state=IDLE, r_Grant=0, r_Ptr=REQ_NO-1 (so requester 0 wins first), r_BeatCntr=0.
REQ-042 On rstn low, asynchronously: dn_Valid=0, dn_Last=0, dn_SubVector=0, dn_ID=0, dn_Src=0, o_Busy=0, o_Err=0, up_Ready=0.
REQ-043 Reset asserted mid-vector discards the partial vector; no beat is re-emitted after reset release.

Verification
REQ-044 Requesters 0 and 2 each offer one 8-beat vector, dn_Ready=1 -> 8 beats with dn_Src=0, then 8 beats with dn_Src=2, no bubble, o_Busy falls after beat 16.
REQ-045 All 4 requesters continuously valid for 8 vectors -> grant order 0,1,2,3,0,1,2,3, each exactly 8 contiguous beats.
REQ-046 dn_Ready low for 3 cycles at beat 4 of a vector -> dn outputs held constant, up_Ready=0 for those cycles, no beat lost or duplicated.
REQ-047 Requester 1 asserts up_Last on beat 5 (r_BeatCntr=4) -> beat forwarded with dn_Last=1, o_Err=1, grant passes to the next valid requester.
REQ-048 rstn pulsed low at beat 3 of a vector -> all outputs 0 immediately; after release, requester 0 wins first and the new vector starts with r_BeatCntr=0.
REQ-049 Grantee drops up_Valid for 2 cycles at beat 6 while requester 3 is valid -> grant held; requester 3 is granted only after beat 8 completes.

Source files
------------

// File: rtl/cnt1_vec_arb_if.sv
// cnt1_vec_arb_if: requester-side beats plus the single cnt1-side beat stream.
interface cnt1_vec_arb_if #(
  parameter int REQ_NO = 4,
  parameter int BUS_WIDTH = 128,
  parameter int VEC_ID_WIDTH = 16
);
  localparam int SRC_WIDTH = REQ_NO > 1 ? $clog2(REQ_NO) : 1;
  logic [REQ_NO*BUS_WIDTH-1:0] up_Vector;
  logic [REQ_NO*VEC_ID_WIDTH-1:0] up_ID;
  logic [REQ_NO-1:0] up_Valid;
  logic [REQ_NO-1:0] up_Last;
  logic [REQ_NO-1:0] up_Ready;
  logic [BUS_WIDTH-1:0] dn_SubVector;
  logic [VEC_ID_WIDTH-1:0] dn_ID;
  logic dn_Valid;
  logic dn_Last;
  logic [SRC_WIDTH-1:0] dn_Src;
  logic dn_Ready;
  modport slave (
    input up_Vector, up_ID, up_Valid, up_Last, dn_Ready,
    output up_Ready, dn_SubVector, dn_ID, dn_Valid, dn_Last, dn_Src
  );
  modport master (
    output up_Vector, up_ID, up_Valid, up_Last, dn_Ready,
    input up_Ready, dn_SubVector, dn_ID, dn_Valid, dn_Last, dn_Src
  );
endinterface

// File: rtl/cnt1_vec_arb.sv
// cnt1_vec_arb: round-robin, vector-granular arbiter feeding one cnt1 pipeline through a single output slot.
module cnt1_vec_arb #(
  parameter int REQ_NO = 4,
  parameter int VECTOR_WIDTH = 920,
  parameter int BUS_WIDTH = 128,
  parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int VEC_ID_WIDTH = 16
) (
  input logic clk,
  input logic rstn,
  cnt1_vec_arb_if.slave bus,
  output logic o_Busy,
  output logic o_Err
);
  localparam int SRC_WIDTH = REQ_NO > 1 ? $clog2(REQ_NO) : 1;
  localparam int BEAT_CNTR_WIDTH = SUB_VECTOR_NO > 1 ? $clog2(SUB_VECTOR_NO) : 1;
  localparam logic [BEAT_CNTR_WIDTH-1:0] LAST_BEAT = BEAT_CNTR_WIDTH'(SUB_VECTOR_NO - 1);
  localparam logic [REQ_NO-1:0] ONE = 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [SRC_WIDTH-1:0] grant_q, grant_d, ptr_q, ptr_d, src_q, src_d;
  logic [BEAT_CNTR_WIDTH-1:0] beat_q, beat_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [VEC_ID_WIDTH-1:0] id_q, id_d;
  logic valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic slot_free, up_xfer, g_last, vec_end;
  logic [REQ_NO-1:0] cand;
  // first valid requester after p in circular order; p itself is searched last
  function automatic logic [SRC_WIDTH-1:0] arb(input logic [SRC_WIDTH-1:0] p, input logic [REQ_NO-1:0] v);
    arb = p;
    for (int i = REQ_NO; i >= 1; i--)
      if (v[(int'(p) + i) % REQ_NO]) arb = SRC_WIDTH'((int'(p) + i) % REQ_NO);
  endfunction
  always_comb begin
    slot_free = !valid_q || bus.dn_Ready;
    g_last = bus.up_Last[grant_q];
    up_xfer = (state_q == BURST) && bus.up_Valid[grant_q] && slot_free;
    vec_end = up_xfer && (beat_q == LAST_BEAT || g_last);
    // a grantee that just ended its stream must not win the re-arbitration on its stale valid
    cand = bus.up_Valid & ~((vec_end && g_last) ? (ONE << grant_q) : '0);
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    beat_d = beat_q;
    if (state_q == IDLE) begin
      state_d = |cand ? BURST : IDLE;
      grant_d = |cand ? arb(ptr_q, cand) : grant_q;
    end else if (vec_end) begin
      ptr_d = grant_q;
      state_d = |cand ? BURST : IDLE;
      grant_d = |cand ? arb(grant_q, cand) : grant_q;
      beat_d = '0;
    end else if (up_xfer) begin
      beat_d = beat_q + 1'b1;
    end
    valid_d = up_xfer || (valid_q && !bus.dn_Ready);
    data_d = up_xfer ? bus.up_Vector[grant_q*BUS_WIDTH +: BUS_WIDTH] : data_q;
    id_d = up_xfer ? bus.up_ID[grant_q*VEC_ID_WIDTH +: VEC_ID_WIDTH] : id_q;
    last_d = up_xfer ? g_last : last_q;
    src_d = up_xfer ? grant_q : src_q;
    err_d = err_q || (up_xfer && g_last && beat_q != LAST_BEAT);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= SRC_WIDTH'(REQ_NO - 1);
      beat_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      id_q <= '0;
      last_q <= 1'b0;
      src_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      beat_q <= beat_d;
      valid_q <= valid_d;
      data_q <= data_d;
      id_q <= id_d;
      last_q <= last_d;
      src_q <= src_d;
      err_q <= err_d;
    end
  end
  assign bus.up_Ready = (state_q == BURST && slot_free) ? (ONE << grant_q) : '0;
  assign bus.dn_SubVector = data_q;
  assign bus.dn_ID = id_q;
  assign bus.dn_Valid = valid_q;
  assign bus.dn_Last = last_q;
  assign bus.dn_Src = src_q;
  assign o_Busy = state_q == BURST;
  assign o_Err = err_q;
endmodule

// File: tb/tb_cnt1_vec_arb.sv
// tb_cnt1_vec_arb: per-requester beat queues drive the arbiter; a round-robin vector model predicts the dn stream.
module tb_cnt1_vec_arb;
  localparam int RN = 4;
  localparam int BW = 128;
  localparam int IW = 16;
  localparam int SV = 8;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic o_Busy, o_Err;
  cnt1_vec_arb_if #(.REQ_NO(RN), .BUS_WIDTH(BW), .VEC_ID_WIDTH(IW)) bus();
  cnt1_vec_arb #(.REQ_NO(RN), .VECTOR_WIDTH(920), .BUS_WIDTH(BW), .SUB_VECTOR_NO(SV), .VEC_ID_WIDTH(IW))
    dut (.clk(clk), .rstn(rstn), .bus(bus), .o_Busy(o_Busy), .o_Err(o_Err));
  always #5 clk = ~clk;
  typedef struct {logic [BW-1:0] d; logic [IW-1:0] id; logic last; int src;} beat_t;
  beat_t pend[RN][$];
  beat_t given[RN][$];
  beat_t obs[$];
  beat_t exp_q[$];
  int obs_cyc[$];
  logic [RN-1:0] hold;
  int sent[RN];
  int cyc, m_ptr, checks, errors;
  bit exp_err;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic clear_all();
    for (int k = 0; k < RN; k++) begin
      pend[k].delete();
      given[k].delete();
      sent[k] = 0;
    end
    obs.delete();
    obs_cyc.delete();
    hold = '0;
    exp_err = 1'b0;
    bus.up_Valid = '0;
    bus.up_Last = '0;
    bus.up_Vector = '0;
    bus.up_ID = '0;
    bus.dn_Ready = 1'b1;
  endtask
  task automatic reset_dut();
    rstn = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ptr = RN - 1;
  endtask
  task automatic add_vec(input int k, input int n, input bit last_end);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x.d = {$urandom, $urandom, $urandom, $urandom};
      x.id = IW'($urandom);
      x.last = last_end && b == n - 1;
      x.src = k;
      pend[k].push_back(x);
      given[k].push_back(x);
    end
    if (last_end && n != SV) exp_err = 1'b1;
  endtask
  // one clock: drive at edge+1, sample handshakes at edge+8, return at next edge+1
  task automatic cycle();
    beat_t x;
    for (int k = 0; k < RN; k++) begin
      bus.up_Valid[k] = pend[k].size() > 0 && !hold[k];
      if (pend[k].size() > 0) begin
        bus.up_Vector[k*BW +: BW] = pend[k][0].d;
        bus.up_ID[k*IW +: IW] = pend[k][0].id;
        bus.up_Last[k] = pend[k][0].last;
      end else begin
        bus.up_Last[k] = 1'b0;
      end
    end
    #7;
    for (int k = 0; k < RN; k++)
      if (bus.up_Valid[k] && bus.up_Ready[k]) begin
        void'(pend[k].pop_front());
        sent[k]++;
      end
    if (bus.dn_Valid && bus.dn_Ready) begin
      x.d = bus.dn_SubVector;
      x.id = bus.dn_ID;
      x.last = bus.dn_Last;
      x.src = int'(bus.dn_Src);
      obs.push_back(x);
      obs_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  function automatic bit pending();
    for (int k = 0; k < RN; k++) if (pend[k].size() > 0) return 1'b1;
    return bus.dn_Valid;
  endfunction
  task automatic run(input int budget, input bit rnd);
    int n = 0;
    while (pending() && n < budget) begin
      bus.dn_Ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      n++;
    end
    bus.dn_Ready = 1'b1;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL run_timeout: stream not drained after %0d cycles", n);
    end
  endtask
  // whole vectors go round-robin from the last grantee among requesters still holding beats
  task automatic model();
    beat_t g[RN][$];
    beat_t x;
    int p, w, n;
    for (int k = 0; k < RN; k++) g[k] = given[k];
    p = m_ptr;
    exp_q.delete();
    while (1) begin
      w = -1;
      for (int i = 1; i <= RN; i++) if (w < 0 && g[(p + i) % RN].size() > 0) w = (p + i) % RN;
      if (w < 0) break;
      n = 0;
      do begin
        x = g[w].pop_front();
        exp_q.push_back(x);
        n++;
      end while (n < SV && !x.last);
      p = w;
    end
    m_ptr = p;
  endtask
  task automatic test_reset();
    #1;
    reset_dut();
    checks++;
    if (bus.dn_Valid !== 1'b0 || bus.dn_Last !== 1'b0 || bus.dn_Src !== '0) begin
      errors++;
      $display("FAIL reset_dn_ctrl: valid=%b last=%b src=%0d, want 0 0 0", bus.dn_Valid, bus.dn_Last, bus.dn_Src);
    end
    checks++;
    if (bus.dn_SubVector !== '0 || bus.dn_ID !== '0) begin
      errors++;
      $display("FAIL reset_dn_data: data=%h id=%h, want 0", bus.dn_SubVector, bus.dn_ID);
    end
    checks++;
    if (o_Busy !== 1'b0 || o_Err !== 1'b0 || bus.up_Ready !== '0) begin
      errors++;
      $display("FAIL reset_status: busy=%b err=%b up_ready=%b, want 0 0 0000", o_Busy, o_Err, bus.up_Ready);
    end
    repeat (3) cycle();
    checks++;
    if (o_Busy !== 1'b0 || bus.dn_Valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b dn_valid=%b with no requests, want 0 0", o_Busy, bus.dn_Valid);
    end
  endtask
  task automatic test_two_req();
    reset_dut();
    add_vec(0, SV, 1'b1);
    add_vec(2, SV, 1'b1);
    model();
    run(200, 1'b0);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL two_req_count: got %0d beats, want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].id !== exp_q[i].id || obs[i].last !== exp_q[i].last || obs[i].src != exp_q[i].src) begin
        errors++;
        $display("FAIL two_req_beat%0d: src=%0d last=%b data=%h, want src=%0d last=%b data=%h", i, obs[i].src, obs[i].last, obs[i].d, exp_q[i].src, exp_q[i].last, exp_q[i].d);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != obs_cyc[i-1] + 1) begin
        errors++;
        $display("FAIL two_req_bubble: beat %0d at cycle %0d, want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
      end
    end
    checks++;
    if (o_Busy !== 1'b0 || o_Err !== 1'b0) begin
      errors++;
      $display("FAIL two_req_end: busy=%b err=%b, want 0 0", o_Busy, o_Err);
    end
  endtask
  task automatic test_round_robin();
    reset_dut();
    for (int k = 0; k < RN; k++) begin
      add_vec(k, SV, 1'b0);
      add_vec(k, SV, 1'b1);
    end
    model();
    run(400, 1'b0);
    checks++;
    if (obs.size() != 8 * SV) begin
      errors++;
      $display("FAIL rr_count: got %0d beats, want %0d", obs.size(), 8 * SV);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].src != (i / SV) % RN) begin
        errors++;
        $display("FAIL rr_beat%0d: src=%0d data=%h, want src=%0d data=%h", i, obs[i].src, obs[i].d, (i / SV) % RN, exp_q[i].d);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != obs_cyc[i-1] + 1) begin
        errors++;
        $display("FAIL rr_bubble: beat %0d at cycle %0d, want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
      end
    end
  endtask
  task automatic test_stall();
    logic [BW-1:0] sd;
    logic [IW-1:0] si;
    int n = 0;
    reset_dut();
    add_vec(1, SV, 1'b1);
    model();
    while (!(obs.size() == 3 && bus.dn_Valid) && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL stall_reach: beat 4 never presented, got %0d beats", obs.size());
    end
    bus.dn_Ready = 1'b0;
    sd = bus.dn_SubVector;
    si = bus.dn_ID;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (bus.dn_SubVector !== sd || bus.dn_ID !== si || bus.dn_Valid !== 1'b1 || bus.up_Ready !== '0) begin
        errors++;
        $display("FAIL stall_hold%0d: data=%h valid=%b up_ready=%b, want data=%h valid=1 up_ready=0000", c, bus.dn_SubVector, bus.dn_Valid, bus.up_Ready, sd);
      end
    end
    bus.dn_Ready = 1'b1;
    run(100, 1'b0);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].id !== exp_q[i].id || obs[i].src != exp_q[i].src) begin
        errors++;
        $display("FAIL stall_beat%0d: src=%0d data=%h, want src=%0d data=%h", i, obs[i].src, obs[i].d, exp_q[i].src, exp_q[i].d);
      end
    end
  endtask
  task automatic test_early_last();
    reset_dut();
    add_vec(1, 5, 1'b1);
    add_vec(2, SV, 1'b1);
    model();
    run(200, 1'b0);
    checks++;
    if (obs.size() != 13) begin
      errors++;
      $display("FAIL early_count: got %0d beats, want 13", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].last !== exp_q[i].last || obs[i].src != exp_q[i].src) begin
        errors++;
        $display("FAIL early_beat%0d: src=%0d last=%b, want src=%0d last=%b", i, obs[i].src, obs[i].last, exp_q[i].src, exp_q[i].last);
      end
    end
    checks++;
    if (obs.size() > 5 && (obs[4].last !== 1'b1 || obs[5].src != 2)) begin
      errors++;
      $display("FAIL early_handoff: beat5 last=%b beat6 src=%0d, want 1 and 2", obs[4].last, obs[5].src);
    end
    checks++;
    if (o_Err !== 1'b1) begin
      errors++;
      $display("FAIL early_err: o_Err=%b, want 1", o_Err);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    reset_dut();
    add_vec(1, SV, 1'b1);
    while (sent[1] < 3 && n < 50) begin
      cycle();
      n++;
    end
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.dn_Valid !== 1'b0 || bus.dn_SubVector !== '0 || bus.dn_ID !== '0 || bus.dn_Src !== '0 || bus.dn_Last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_dn: valid=%b data=%h id=%h src=%0d, want all 0", bus.dn_Valid, bus.dn_SubVector, bus.dn_ID, bus.dn_Src);
    end
    checks++;
    if (o_Busy !== 1'b0 || o_Err !== 1'b0 || bus.up_Ready !== '0) begin
      errors++;
      $display("FAIL midreset_status: busy=%b err=%b up_ready=%b, want 0 0 0000", o_Busy, o_Err, bus.up_Ready);
    end
    clear_all();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ptr = RN - 1;
    add_vec(3, SV, 1'b1);
    add_vec(0, SV, 1'b1);
    model();
    run(200, 1'b0);
    checks++;
    if (obs.size() != 2 * SV || obs[0].src != 0) begin
      errors++;
      $display("FAIL midreset_restart: %0d beats first src=%0d, want %0d beats first src=0", obs.size(), obs.size() > 0 ? obs[0].src : -1, 2 * SV);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].src != exp_q[i].src) begin
        errors++;
        $display("FAIL midreset_beat%0d: src=%0d data=%h, want src=%0d data=%h", i, obs[i].src, obs[i].d, exp_q[i].src, exp_q[i].d);
      end
    end
  endtask
  task automatic test_bubble();
    int n = 0;
    reset_dut();
    add_vec(0, SV, 1'b1);
    add_vec(3, SV, 1'b1);
    model();
    while (sent[0] < 6 && n < 50) begin
      cycle();
      n++;
    end
    hold[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if (bus.up_Ready[3] !== 1'b0 || o_Busy !== 1'b1) begin
        errors++;
        $display("FAIL bubble_hold%0d: up_ready=%b busy=%b, want up_ready[3]=0 busy=1", c, bus.up_Ready, o_Busy);
      end
    end
    hold[0] = 1'b0;
    run(200, 1'b0);
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bubble_count: got %0d beats, want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d !== exp_q[i].d || obs[i].src != exp_q[i].src) begin
        errors++;
        $display("FAIL bubble_beat%0d: src=%0d data=%h, want src=%0d data=%h", i, obs[i].src, obs[i].d, exp_q[i].src, exp_q[i].d);
      end
    end
  endtask
  task automatic test_random();
    int nv, len;
    for (int it = 0; it < 6; it++) begin
      reset_dut();
      for (int k = 0; k < RN; k++) begin
        nv = (k == it % RN) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        for (int v = 0; v < nv; v++) begin
          len = (v == nv - 1) ? $urandom_range(1, SV) : SV;
          add_vec(k, len, v == nv - 1);
        end
      end
      model();
      run(2000, 1'b1);
      checks++;
      if (obs.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d beats, want %0d", it, obs.size(), exp_q.size());
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs[i].d !== exp_q[i].d || obs[i].id !== exp_q[i].id || obs[i].last !== exp_q[i].last || obs[i].src != exp_q[i].src) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: src=%0d last=%b data=%h, want src=%0d last=%b data=%h", it, i, obs[i].src, obs[i].last, obs[i].d, exp_q[i].src, exp_q[i].last, exp_q[i].d);
        end
      end
      checks++;
      if (o_Err !== exp_err) begin
        errors++;
        $display("FAIL rand%0d_err: o_Err=%b, want %b", it, o_Err, exp_err);
      end
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_two_req();
    test_round_robin();
    test_stall();
    test_early_last();
    test_reset_mid();
    test_bubble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
